number_input_buffer: RTL and testbench

NUMBER_INPUT_BUFFER -- requirements
Module: number_input_buffer

---
 rtl/number_input_buffer.sv | 158 +++++++++++++++
 tb/tb_number_input_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/number_input_buffer.sv
// number_input_buffer
//   Collects decimal digits typed on a PS/2 keyboard (scan code set 2),
//   shows them as packed BCD while they are typed, and on Enter converts
//   them to a 32-bit binary number handed to the datapath.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   scancode[7:0]  in   PS/2 byte from the keyboard receiver
//   scancode_valid in   one-cycle strobe qualifying scancode
//   clear          in   consumer acknowledge for num_buffer
//   num_buffer     out  binary value of the last committed number
//   num_valid      out  num_buffer holds an unacknowledged number
//   bcd_digits     out  digits being typed, newest digit in [3:0]
//   digit_count    out  number of digits held in bcd_digits
//   busy           out  BCD-to-binary conversion in progress
module number_input_buffer #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  scancode,
  input  logic        scancode_valid,
  input  logic        clear,
  output logic [31:0] num_buffer,
  output logic        num_valid,
  output logic [31:0] bcd_digits,
  output logic [3:0]  digit_count,
  output logic        busy
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    CONV
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [3:0]  conv_left;   // digits still to fold into acc

  logic [4:0]  key_dec;     // {is_digit, value}
  logic        valid_eff;   // num_valid after a same-cycle clear
  logic [2:0]  conv_sel;
  logic [4:0]  conv_pos;
  logic [3:0]  conv_digit;
  logic [31:0] acc_next;

  // Map a make code to {hit, digit}; hit=0 for non-digit keys.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h45:   r = {1'b1, 4'd0};
      8'h16:   r = {1'b1, 4'd1};
      8'h1E:   r = {1'b1, 4'd2};
      8'h26:   r = {1'b1, 4'd3};
      8'h25:   r = {1'b1, 4'd4};
      8'h2E:   r = {1'b1, 4'd5};
      8'h36:   r = {1'b1, 4'd6};
      8'h3D:   r = {1'b1, 4'd7};
      8'h3E:   r = {1'b1, 4'd8};
      8'h46:   r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // acc*10 + d built from shifts; cannot overflow for 8 decimal digits.
  function automatic logic [31:0] mac10(input logic [31:0] a, input logic [3:0] d);
    return {a[28:0], 3'b000} + {a[30:0], 1'b0} + {28'd0, d};
  endfunction

  always_comb begin
    key_dec   = decode_digit(scancode);
    valid_eff = num_valid & ~clear;
    // Oldest (most significant) remaining digit sits at nibble conv_left-1.
    // conv_left is 1..8 in CONV, so the 3-bit wrap maps 8 -> nibble 7.
    conv_sel   = conv_left[2:0] - 3'd1;
    conv_pos   = {conv_sel, 2'b00};
    conv_digit = bcd_digits[conv_pos +: 4];
    acc_next   = mac10(acc, conv_digit);
  end

  assign busy = (state == CONV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= 32'd0;
      conv_left   <= 4'd0;
      num_buffer  <= 32'd0;
      num_valid   <= 1'b0;
      bcd_digits  <= 32'd0;
      digit_count <= 4'd0;
    end else if (state == CONV) begin
      // Conversion: one digit per cycle, scancodes and clear are dropped.
      acc       <= acc_next;
      conv_left <= conv_left - 4'd1;
      if (conv_left == 4'd1) begin
        num_buffer  <= acc_next;
        num_valid   <= 1'b1;
        bcd_digits  <= 32'd0;
        digit_count <= 4'd0;
        state       <= IDLE;
      end
    end else begin
      // Clear is applied first; any later assignment in this cycle wins.
      if (clear) num_valid <= 1'b0;
      if (scancode_valid) begin
        case (state)
          IDLE: begin
            if (scancode == SC_BREAK) begin
              state <= BRK;
            end else if (scancode == SC_EXT) begin
              state <= EXT;
            end else if (key_dec[4]) begin
              if (!valid_eff && digit_count < MAX_CNT) begin
                bcd_digits  <= {bcd_digits[27:0], key_dec[3:0]};
                digit_count <= digit_count + 4'd1;
              end
            end else if (scancode == SC_ENTER) begin
              if (!valid_eff && digit_count != 4'd0) begin
                state     <= CONV;
                acc       <= 32'd0;
                conv_left <= digit_count;
              end
            end else if (scancode == SC_BKSP) begin
              if (!valid_eff && digit_count != 4'd0) begin
                bcd_digits  <= {4'd0, bcd_digits[31:4]};
                digit_count <= digit_count - 4'd1;
              end
            end else if (scancode == SC_ESC) begin
              bcd_digits  <= 32'd0;
              digit_count <= 4'd0;
              num_buffer  <= 32'd0;
              num_valid   <= 1'b0;
            end
          end
          BRK:     state <= IDLE;
          EXT:     state <= (scancode == SC_BREAK) ? EXT_BRK : IDLE;
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_number_input_buffer.sv
module tb_number_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  scancode;
  logic        scancode_valid;
  logic        clear;
  logic [31:0] num_buffer;
  logic        num_valid;
  logic [31:0] bcd_digits;
  logic [3:0]  digit_count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  number_input_buffer #(.MAX_DIGITS(8)) dut (
    .clk(clk),
    .rst(rst),
    .scancode(scancode),
    .scancode_valid(scancode_valid),
    .clear(clear),
    .num_buffer(num_buffer),
    .num_valid(num_valid),
    .bcd_digits(bcd_digits),
    .digit_count(digit_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scancode       = b;
    scancode_valid = 1'b1;
    @(negedge clk);
    scancode_valid = 1'b0;
  endtask

  // Full key press: make, break prefix, make again.
  task automatic key(input logic [7:0] mk);
    send_byte(mk);
    send_byte(8'hF0);
    send_byte(mk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Called right after Enter is taken; counts cycles to num_valid.
  task automatic wait_commit(input string tag, input int n_exp, input logic [31:0] val_exp);
    int n = 0;
    while (!num_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_lat"}, n, n_exp);
    check_val({tag, "_num"}, num_buffer, val_exp);
    check_val({tag, "_vld"}, {31'd0, num_valid}, 32'd1);
    check_val({tag, "_cnt"}, {28'd0, digit_count}, 32'd0);
    check_val({tag, "_bcd"}, bcd_digits, 32'd0);
  endtask

  initial begin
    rst = 1'b0; scancode = 8'h00; scancode_valid = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_num", num_buffer, 32'd0);
    check_val("rst_vld", {31'd0, num_valid}, 32'd0);
    check_val("rst_bcd", bcd_digits, 32'd0);
    check_val("rst_cnt", {28'd0, digit_count}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;

    // 1,2,3 Enter -> 123
    key(8'h16); key(8'h1E); key(8'h26);
    check_val("t123_bcd", bcd_digits, 32'h123);
    check_val("t123_cnt", {28'd0, digit_count}, 32'd3);
    send_byte(8'h5A);
    check_val("t123_busy0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_val("t123_busy1", {31'd0, busy}, 32'd1);
    check_val("t123_vld1", {31'd0, num_valid}, 32'd0);
    @(negedge clk);
    check_val("t123_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_val("t123_num", num_buffer, 32'h0000007B);
    check_val("t123_vld", {31'd0, num_valid}, 32'd1);
    check_val("t123_cnt0", {28'd0, digit_count}, 32'd0);
    check_val("t123_busy3", {31'd0, busy}, 32'd0);

    // Digits ignored while valid; clear keeps num_buffer
    key(8'h26);
    check_val("hold_cnt", {28'd0, digit_count}, 32'd0);
    pulse_clear();
    check_val("clr_vld", {31'd0, num_valid}, 32'd0);
    check_val("clr_num", num_buffer, 32'h7B);
    key(8'h26);
    check_val("clr_cnt", {28'd0, digit_count}, 32'd1);
    check_val("clr_bcd", bcd_digits, 32'h3);
    key(8'h76);
    check_val("esc_cnt", {28'd0, digit_count}, 32'd0);
    check_val("esc_num", num_buffer, 32'd0);

    // Backspace at zero digits has no effect
    key(8'h66);
    check_val("bs0_cnt", {28'd0, digit_count}, 32'd0);
    check_val("bs0_bcd", bcd_digits, 32'd0);

    // 4,5,BS,7 Enter -> 47
    key(8'h25); key(8'h2E); key(8'h66); key(8'h3D);
    check_val("t47_bcd", bcd_digits, 32'h47);
    check_val("t47_cnt", {28'd0, digit_count}, 32'd2);
    send_byte(8'h5A);
    wait_commit("t47", 2, 32'h2F);
    pulse_clear();

    // Nine 9s with MAX_DIGITS=8 -> 99999999
    for (int i = 0; i < 9; i++) key(8'h46);
    check_val("t9_cnt", {28'd0, digit_count}, 32'd8);
    check_val("t9_bcd", bcd_digits, 32'h99999999);
    send_byte(8'h5A);
    wait_commit("t9", 8, 32'h05F5E0FF);
    pulse_clear();

    // Extended and break sequences add nothing
    send_byte(8'hE0); send_byte(8'h5A);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    check_val("ext_vld", {31'd0, num_valid}, 32'd0);
    check_val("ext_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hF0); send_byte(8'h16);
    check_val("brk_cnt", {28'd0, digit_count}, 32'd0);
    send_byte(8'h5A);
    check_val("ent0_busy", {31'd0, busy}, 32'd0);
    key(8'h16);
    check_val("resume_cnt", {28'd0, digit_count}, 32'd1);
    send_byte(8'h5A);
    wait_commit("t1", 1, 32'd1);

    // Clear and digit in the same cycle: digit accepted
    @(negedge clk);
    clear = 1'b1; scancode = 8'h1E; scancode_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; scancode_valid = 1'b0;
    check_val("same_vld", {31'd0, num_valid}, 32'd0);
    check_val("same_cnt", {28'd0, digit_count}, 32'd1);
    check_val("same_bcd", bcd_digits, 32'h2);
    key(8'h76);

    // 5,6 Enter with a break prefix arriving during CONV (must be dropped)
    key(8'h2E); key(8'h36);
    send_byte(8'h5A);
    send_byte(8'hF0);
    check_val("drop_num", num_buffer, 32'h38);
    check_val("drop_vld", {31'd0, num_valid}, 32'd1);
    pulse_clear();
    send_byte(8'h16);
    check_val("drop_cnt", {28'd0, digit_count}, 32'd1);
    key(8'h76);
    send_byte(8'h76);
    pulse_clear();

    // Reset during CONV aborts with no commit
    check_val("pre_rst_vld", {31'd0, num_valid}, 32'd0);
    key(8'h3E); key(8'h3E);
    send_byte(8'h5A);
    check_val("conv_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_cnt", {28'd0, digit_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("abort_vld", {31'd0, num_valid}, 32'd0);
    check_val("abort_num", num_buffer, 32'd0);
    check_val("abort_cnt", {28'd0, digit_count}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    key(8'h16);
    check_val("abort_idle", {28'd0, digit_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
